// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// round_robin_arbiter -- N-way round-robin arbiter, registered one-hot grant
// Revision: 1.0
// ============================================================================
module round_robin_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         asrst,
  input  logic         en,
  input  logic [N-1:0] req_vld,
  output logic [N-1:0] o_grant
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] c_last_idx = LW'(N - 1);

  logic [N-1:0]  grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] w_idx;
  logic          w_found;

  // Walk indices last+1 .. last (wrapping); the first requester wins.
  always_comb begin
    grant_d = '0;
    last_d  = last_q;
    w_idx   = last_q;
    w_found = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        w_idx = (w_idx == c_last_idx) ? '0 : w_idx + LW'(1);
        if (!w_found && req_vld[w_idx]) begin
          w_found        = 1'b1;
          grant_d        = '0;
          grant_d[w_idx] = 1'b1;
          last_d         = w_idx;
        end
      end
    end
  end

  // Reset pointer to N-1 so index 0 is searched first.
  always_ff @(posedge clk) begin
    if (!asrst) begin
      grant_q <= '0;
      last_q  <= c_last_idx;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign o_grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// tb_round_robin_arbiter -- directed + random checks against a modulo-N model
// Revision: 1.0
// ============================================================================
module tb_round_robin_arbiter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         asrst;
  logic         en;
  logic [N-1:0] req_vld;
  logic [N-1:0] o_grant;

  int errors = 0;
  int checks = 0;

  int           m_last;
  logic [N-1:0] m_grant;
  int           wait_c [N];

  round_robin_arbiter #(.N(N)) dut (
    .clk     (clk),
    .asrst   (asrst),
    .en      (en),
    .req_vld (req_vld),
    .o_grant (o_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic e, input logic [N-1:0] r);
    logic [N-1:0] subset_v;
    logic [N-1:0] fair_v;
    int           idx;
    bit           taken;
    asrst   = rst_n;
    en      = e;
    req_vld = r;
    @(posedge clk);
    #1;
    // Reference: scan (last+1 .. last+N) mod N, first requester wins.
    m_grant = '0;
    if (!rst_n) begin
      m_last = N - 1;
    end else if (e && r != '0) begin
      taken = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!taken && r[idx]) begin
          taken         = 1'b1;
          m_grant[idx]  = 1'b1;
          m_last        = idx;
        end
      end
    end
    chk("grant", o_grant, m_grant);
    chk("onehot0", {{(N-1){1'b0}}, $onehot0(o_grant)}, {{(N-1){1'b0}}, 1'b1});
    subset_v = rst_n ? (o_grant & ~r) : o_grant;
    chk("subset", subset_v, '0);
    fair_v = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && e && r[i] && !o_grant[i]) wait_c[i]++;
      else                                    wait_c[i] = 0;
      if (wait_c[i] >= N) fair_v[i] = 1'b1;
    end
    chk("fairness", fair_v, '0);
  endtask

  logic [N-1:0] seq25 [8];

  initial begin
    seq25[0] = 3'b001; seq25[1] = 3'b010; seq25[2] = 3'b100; seq25[3] = 3'b001;
    seq25[4] = 3'b010; seq25[5] = 3'b100; seq25[6] = 3'b001; seq25[7] = 3'b010;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    m_last  = N - 1;
    asrst   = 1'b0;
    en      = 1'b0;
    req_vld = '0;

    // Reset, then full rotation from index 0.
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 3'b111);
      chk("rotate_tbl", o_grant, seq25[i]);
    end

    // Idle requests hold the pointer; sole requester granted each cycle.
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'b001);
      chk("sole_req", o_grant, 3'b001);
    end

    // Pointer at 0: 110 alternates, then 011 starts from index 0.
    step(1'b1, 1'b1, 3'b110); chk("p110_a", o_grant, 3'b010);
    step(1'b1, 1'b1, 3'b110); chk("p110_b", o_grant, 3'b100);
    step(1'b1, 1'b1, 3'b011); chk("p011_a", o_grant, 3'b001);
    step(1'b1, 1'b1, 3'b011); chk("p011_b", o_grant, 3'b010);
    step(1'b1, 1'b1, 3'b011); chk("p011_c", o_grant, 3'b001);

    // Pointer at 0: 101 alternates 100/001; en=0 blocks everything.
    step(1'b1, 1'b1, 3'b101); chk("p101_a", o_grant, 3'b100);
    step(1'b1, 1'b1, 3'b101); chk("p101_b", o_grant, 3'b001);
    step(1'b1, 1'b1, 3'b101); chk("p101_c", o_grant, 3'b100);
    step(1'b1, 1'b0, 3'b111); chk("en_off_a", o_grant, 3'b000);
    step(1'b1, 1'b0, 3'b111); chk("en_off_b", o_grant, 3'b000);
    step(1'b1, 1'b1, 3'b111); chk("en_resume", o_grant, 3'b001);

    // Mid-rotation reset discards history.
    step(1'b1, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b111); chk("mid_rst", o_grant, 3'b000);
    step(1'b1, 1'b1, 3'b111); chk("post_rst", o_grant, 3'b001);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) != 0),
           N'($urandom_range(0, (1 << N) - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
